// File: rtl/artau_multi_pulse.sv
// Multi-pulse radar burst timer: ranges each echo and flags closing threats.
// Optional blind-zone echo gating is enabled with ARTAU_RANGE_GATE_EN.
module artau_multi_pulse #(
  parameter int NUM_PULSES      = 2,
  parameter int PULSE_CYCLES    = 300,
  parameter int LISTEN_TIMEOUT  = 2000,
  parameter int HOLD_CYCLES     = 3000,
  parameter int DIST_PER_CYC    = 150,
  parameter int CYCLES_PER_SEC  = 1000000,
  parameter int MIN_ECHO_CYCLES = 10,
  localparam int PW = (NUM_PULSES > 1) ? $clog2(NUM_PULSES) : 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          scan_for_target,
  input  logic          radar_echo,
  input  logic [31:0]   jet_speed,
  input  logic [31:0]   max_safe_distance,
  output logic          radar_pulse_trigger,
  output logic [31:0]   distance_to_target,
  output logic          threat_detected,
  output logic [PW-1:0] pulse_index,
  output logic [1:0]    ARTAU_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EMIT   = 2'd1,
    S_LISTEN = 2'd2,
    S_ASSESS = 2'd3
  } state_t;

`ifdef ARTAU_RANGE_GATE_EN
  localparam bit GATE_EN = 1'b1;
`else
  localparam bit GATE_EN = 1'b0;
`endif

  localparam int unsigned GATE_MIN =
    GATE_EN ? MIN_ECHO_CYCLES : 0;

  state_t        r_state, w_state;
  logic [31:0]   r_emit_cnt, w_emit_cnt;
  logic [31:0]   r_echo_cnt, w_echo_cnt;
  logic [31:0]   r_hold_cnt, w_hold_cnt;
  logic [31:0]   r_burst, w_burst;
  logic [31:0]   r_d_first, w_d_first;
  logic [31:0]   r_dist, w_dist;
  logic          r_threat, w_threat;
  logic [PW-1:0] r_pidx, w_pidx;

  logic          w_echo_ok;
  logic [63:0]   w_prod;
  logic [31:0]   w_range;
  logic [63:0]   w_comp64;
  logic [32:0]   w_comp33;
  logic [32:0]   w_sum;
  logic          w_threat_eval;
  logic          w_last_pulse;
  logic [31:0]   w_burst_inc;

  assign w_echo_ok = radar_echo & (r_echo_cnt >= GATE_MIN);

  // Range saturates rather than wrapping on a very late echo
  assign w_prod  = 64'(DIST_PER_CYC) * 64'(r_echo_cnt);
  assign w_range = (|w_prod[63:32]) ? 32'hFFFF_FFFF
                                    : w_prod[31:0];

  assign w_comp64 = (64'(jet_speed) * 64'(r_burst))
                    / 64'(CYCLES_PER_SEC);
  assign w_comp33 = (|w_comp64[63:32])
                    ? {1'b0, 32'hFFFF_FFFF}
                    : {1'b0, w_comp64[31:0]};
  assign w_sum    = {1'b0, w_range} + w_comp33;

  assign w_threat_eval = (w_range < max_safe_distance)
                       && (w_sum < {1'b0, r_d_first});

  assign w_last_pulse =
    (32'(r_pidx) >= 32'(NUM_PULSES - 1));

  // Burst timer only runs once the first echo has seeded it
  assign w_burst_inc = (r_burst != 32'd0) ? r_burst + 32'd1
                                          : r_burst;

  always_comb begin
    w_state    = r_state;
    w_emit_cnt = r_emit_cnt;
    w_echo_cnt = r_echo_cnt;
    w_hold_cnt = r_hold_cnt;
    w_burst    = r_burst;
    w_d_first  = r_d_first;
    w_dist     = r_dist;
    w_threat   = r_threat;
    w_pidx     = r_pidx;
    unique case (r_state)
      S_IDLE: begin
        if (scan_for_target) begin
          w_state    = S_EMIT;
          w_emit_cnt = 32'd0;
          w_pidx     = '0;
          w_burst    = 32'd0;
        end
      end
      S_EMIT: begin
        w_burst = w_burst_inc;
        if (r_emit_cnt == 32'(PULSE_CYCLES - 1)) begin
          w_state    = S_LISTEN;
          w_echo_cnt = 32'd1;
        end else begin
          w_emit_cnt = r_emit_cnt + 32'd1;
        end
      end
      S_LISTEN: begin
        w_burst = w_burst_inc;
        if (w_echo_ok) begin
          w_dist = w_range;
          if (r_pidx == '0) begin
            w_d_first = w_range;
            w_burst   = 32'd1;
          end
          if (!w_last_pulse) begin
            w_state    = S_EMIT;
            w_emit_cnt = 32'd0;
            w_pidx     = r_pidx + PW'(1);
          end else begin
            w_state    = S_ASSESS;
            w_threat   = w_threat_eval;
            w_hold_cnt = 32'd0;
          end
        end else if (r_echo_cnt >= 32'(LISTEN_TIMEOUT)) begin
          w_state  = S_IDLE;
          w_dist   = 32'd0;
          w_threat = 1'b0;
          w_pidx   = '0;
          w_burst  = 32'd0;
        end else begin
          w_echo_cnt = r_echo_cnt + 32'd1;
        end
      end
      S_ASSESS: begin
        if (scan_for_target) begin
          w_state    = S_EMIT;
          w_emit_cnt = 32'd0;
          w_pidx     = '0;
          w_burst    = 32'd0;
          w_hold_cnt = 32'd0;
        end else if (r_hold_cnt == 32'(HOLD_CYCLES - 1)) begin
          w_state    = S_IDLE;
          w_dist     = 32'd0;
          w_threat   = 1'b0;
          w_hold_cnt = 32'd0;
        end else begin
          w_hold_cnt = r_hold_cnt + 32'd1;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_emit_cnt <= 32'd0;
      r_echo_cnt <= 32'd0;
      r_hold_cnt <= 32'd0;
      r_burst    <= 32'd0;
      r_d_first  <= 32'd0;
      r_dist     <= 32'd0;
      r_threat   <= 1'b0;
      r_pidx     <= '0;
    end else begin
      r_state    <= w_state;
      r_emit_cnt <= w_emit_cnt;
      r_echo_cnt <= w_echo_cnt;
      r_hold_cnt <= w_hold_cnt;
      r_burst    <= w_burst;
      r_d_first  <= w_d_first;
      r_dist     <= w_dist;
      r_threat   <= w_threat;
      r_pidx     <= w_pidx;
    end
  end

  assign radar_pulse_trigger = (r_state == S_EMIT);
  assign distance_to_target  = r_dist;
  assign threat_detected     = r_threat;
  assign pulse_index         = r_pidx;
  assign ARTAU_state         = r_state;

endmodule
